// File: rtl/rail_job_sequencer_if.sv
// Job request handshake between the digit source and the sequencer.
// master drives req_valid/req_digit, slave returns req_ready.
interface rail_job_sequencer_if;
  logic       req_valid;
  logic [3:0] req_digit;
  logic       req_ready;

  modport master (
    output req_valid,
    output req_digit,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_digit,
    output req_ready
  );
endinterface

// File: rtl/rail_job_sequencer.sv
// Queues sort digits and steps the rail through move/settle/push/home.
// Ports: clk, reset, req (job handshake), drv_* (driver), busy/job_done/bad_digit/fault/q_count.
module rail_job_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int SETTLE_CYCLES  = 1_000_000,
  parameter int PUSH_CYCLES    = 40_000_000,
  parameter int TIMEOUT_CYCLES = 2**27
) (
  input  logic                        clk,
  input  logic                        reset,
  rail_job_sequencer_if.slave         req,
  output logic                        drv_load,
  output logic [3:0]                  drv_digit,
  input  logic                        drv_at_target,
  output logic                        busy,
  output logic                        job_done,
  output logic                        bad_digit,
  output logic                        fault,
  output logic [$clog2(FIFO_DEPTH):0] q_count
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int MX1  = (SETTLE_CYCLES > PUSH_CYCLES)
                      ? SETTLE_CYCLES : PUSH_CYCLES;
  localparam int MAXC = (MX1 > TIMEOUT_CYCLES) ? MX1 : TIMEOUT_CYCLES;
  localparam int NW   = $clog2(MAXC + 1);

  localparam logic [NW-1:0] CNT_MAX   = NW'(MAXC);
  localparam logic [NW-1:0] SET_LAST  = NW'(SETTLE_CYCLES - 1);
  localparam logic [NW-1:0] PUSH_LAST = NW'(PUSH_CYCLES - 1);
  localparam logic [NW-1:0] TO_LAST   = NW'(TIMEOUT_CYCLES - 1);
  localparam logic [NW-1:0] BLANK     = NW'(2);

  typedef enum logic [2:0] {
    IDLE, MOVE, SETTLE, PUSH, HOME, FAULT
  } state_t;

  state_t          state_q, state_d;
  logic [NW-1:0]   cnt;
  logic [3:0]      digit_q, digit_d;
  logic            done_d;
  logic [3:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            accept, push, pop;
  logic            blank_done;

  assign req.req_ready = (count != CW'(FIFO_DEPTH))
                      && (state_q != FAULT);
  assign accept = req.req_valid && req.req_ready;
  // Out-of-range digits are acknowledged but never stored.
  assign push   = accept && (req.req_digit <= 4'd9);

  // The driver's stop flag is stale for the first two cycles after
  // a new target is loaded.
  assign blank_done = cnt >= BLANK;

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          digit_d = mem[rd_ptr];
          state_d = MOVE;
        end
      end
      MOVE: begin
        if (blank_done && drv_at_target)
          state_d = SETTLE;
        else if (cnt == TO_LAST)
          state_d = FAULT;
      end
      SETTLE: begin
        if (cnt == SET_LAST)
          state_d = PUSH;
      end
      PUSH: begin
        if (cnt == PUSH_LAST) begin
          digit_d = 4'd0;
          state_d = HOME;
        end
      end
      HOME: begin
        if (blank_done && drv_at_target) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt == TO_LAST) begin
          state_d = FAULT;
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt       <= '0;
      digit_q   <= 4'd0;
      job_done  <= 1'b0;
      bad_digit <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      state_q   <= state_d;
      digit_q   <= digit_d;
      job_done  <= done_d;
      bad_digit <= accept && (req.req_digit > 4'd9);
      if (state_d != state_q)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + NW'(1);
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (!push && pop)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= req.req_digit;
  end

  assign drv_load  = (state_q == MOVE) || (state_q == SETTLE)
                  || (state_q == PUSH) || (state_q == HOME);
  assign drv_digit = digit_q;
  assign fault     = state_q == FAULT;
  assign busy      = (state_q != IDLE) || (count != '0);
  assign q_count   = count;

endmodule

// File: tb/tb_rail_job_sequencer.sv
// Scoreboard bench for rail_job_sequencer with a simple driver model.
// Small timing overrides: SETTLE=4, PUSH=8, TIMEOUT=64.
module tb_rail_job_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       drv_load;
  logic [3:0] drv_digit;
  logic       at_target = 1'b0;
  logic       busy, job_done, bad_digit, fault;
  logic [2:0] q_count;

  rail_job_sequencer_if rif();

  rail_job_sequencer #(
    .FIFO_DEPTH     (4),
    .SETTLE_CYCLES  (4),
    .PUSH_CYCLES    (8),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (rif),
    .drv_load      (drv_load),
    .drv_digit     (drv_digit),
    .drv_at_target (at_target),
    .busy          (busy),
    .job_done      (job_done),
    .bad_digit     (bad_digit),
    .fault         (fault),
    .q_count       (q_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  int mode = 0;
  int mcnt = 0;
  int rises = 0, jobs = 0;
  int hi_run = 0, lo_run = 0, gap = 0;
  int pre_home = 0, home_len = 0, last_hi = 0;
  bit gap_en = 1'b0;
  logic       p_load = 1'b0;
  logic [3:0] p_digit = 4'd0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    logic rise;
    #1;
    if (reset) begin
      p_load    = 1'b0;
      p_digit   = 4'd0;
      hi_run    = 0;
      lo_run    = 0;
      mcnt      = 0;
      at_target = 1'b0;
    end else begin
      rise = drv_load && !p_load;
      if (rise) begin
        rises++;
        gap    = lo_run;
        lo_run = 0;
        if (gap_en)
          chk("load_gap", gap, 1);
        chk("sb_pending", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0)
          chk("job_digit", drv_digit, exp_q.pop_front());
      end
      if (drv_load && p_load && p_digit != 0 && drv_digit == 0)
        pre_home = hi_run;
      if (drv_load)
        hi_run = rise ? 1 : hi_run + 1;
      else
        lo_run++;
      if (!drv_load && p_load)
        last_hi = hi_run;
      if (job_done) begin
        jobs++;
        home_len = hi_run - pre_home;
      end
      if (rise || drv_digit != p_digit)
        mcnt = 0;
      else if (mcnt < 1000)
        mcnt++;
      at_target = (mode == 0) ? (mcnt >= 5) : (mode == 1);
      p_load  = drv_load;
      p_digit = drv_digit;
    end
  end

  task automatic push(input logic [3:0] d);
    int n = 0;
    while (!rif.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200)
      chk("push_wait", int'(rif.req_ready), 1);
    rif.req_valid = 1'b1;
    rif.req_digit = d;
    if (d <= 4'd9)
      exp_q.push_back(int'(d));
    @(negedge clk);
    rif.req_valid = 1'b0;
  endtask

  task automatic wait_jobs(input int target);
    int n = 0;
    while (jobs < target && n < 800) begin
      @(negedge clk);
      n++;
    end
    chk("jobs_reached", jobs, target);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, rif.req_ready, 1);
    chk({tag, "_load"}, drv_load, 0);
    chk({tag, "_digit"}, drv_digit, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, job_done, 0);
    chk({tag, "_bad"}, bad_digit, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_qcount"}, q_count, 0);
  endtask

  initial begin
    int n, j0, r0;
    rif.req_valid = 1'b0;
    rif.req_digit = 4'd0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    reset = 1'b0;
    @(negedge clk);

    // single job, driver arrives 5 cycles after each load
    push(4'd4);
    wait_jobs(1);
    chk("t1_pre_home", pre_home, 18);
    chk("t1_home_len", home_len, 6);
    repeat (5) @(negedge clk);
    chk("t1_jobs", jobs, 1);
    chk("t1_busy", busy, 0);
    chk("t1_load", drv_load, 0);

    // fill the queue, check ordering and the refusal when full
    j0 = jobs;
    push(4'd3);
    push(4'd6);
    push(4'd9);
    push(4'd2);
    push(4'd7);
    gap_en = 1'b1;
    chk("t2_qfull", q_count, 4);
    chk("t2_ready", rif.req_ready, 0);
    rif.req_valid = 1'b1;
    rif.req_digit = 4'd8;
    repeat (3) @(negedge clk);
    rif.req_valid = 1'b0;
    chk("t2_refused", q_count, 4);
    wait_jobs(j0 + 5);
    gap_en = 1'b0;
    chk("t2_sb_empty", exp_q.size(), 0);
    @(negedge clk);

    // out-of-range digit
    r0 = rises;
    push(4'd12);
    chk("t3_bad", bad_digit, 1);
    chk("t3_qcount", q_count, 0);
    @(negedge clk);
    chk("t3_bad_pulse", bad_digit, 0);
    repeat (10) @(negedge clk);
    chk("t3_rises", rises, r0);
    chk("t3_load", drv_load, 0);
    chk("t3_busy", busy, 0);

    // stop flag stuck high: only blanking delays MOVE
    mode = 1;
    j0 = jobs;
    push(4'd5);
    wait_jobs(j0 + 1);
    chk("t4_pre_home", pre_home, 15);
    chk("t4_home_len", home_len, 3);
    mode = 0;
    repeat (3) @(negedge clk);

    // driver never arrives
    mode = 2;
    push(4'd5);
    n = 0;
    while (!fault && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t5_fault", fault, 1);
    chk("t5_move_len", last_hi, 64);
    chk("t5_load", drv_load, 0);
    chk("t5_ready", rif.req_ready, 0);
    chk("t5_digit", drv_digit, 5);
    repeat (5) @(negedge clk);
    chk("t5_sticky", fault, 1);
    reset = 1'b1;
    mode = 0;
    @(negedge clk);
    chk_reset("t5rst");
    reset = 1'b0;
    @(negedge clk);

    // reset during PUSH with two jobs waiting
    push(4'd4);
    push(4'd6);
    push(4'd7);
    n = 0;
    while (hi_run < 13 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_in_push", int'(hi_run >= 11 && hi_run <= 18), 1);
    chk("t6_queued", q_count, 2);
    reset = 1'b1;
    @(negedge clk);
    chk_reset("t6rst");
    reset = 1'b0;
    exp_q.delete();
    r0 = rises;
    repeat (10) @(negedge clk);
    chk("t6_idle", rises, r0);
    chk("t6_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
